// File: rtl/serial_pkg.sv
// ============================================================================
// Module : serial_pkg
// Purpose: Shared definitions for the tick-paced serial transmitter:
//          3-bit state encoding and the idle level of the serial line.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_pkg;

  // State encoding, 3 bits wide.
  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_SYNC   = 3'd1;
  localparam logic [2:0] c_ST_START  = 3'd2;
  localparam logic [2:0] c_ST_DATA   = 3'd3;
  localparam logic [2:0] c_ST_PARITY = 3'd4;
  localparam logic [2:0] c_ST_STOP   = 3'd5;

  // Level of the serial line when no frame is in flight (also stop level).
  localparam logic c_LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = c_ST_IDLE,
    S_SYNC   = c_ST_SYNC,
    S_START  = c_ST_START,
    S_DATA   = c_ST_DATA,
    S_PARITY = c_ST_PARITY,
    S_STOP   = c_ST_STOP
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/tick_serial_tx.sv
// ============================================================================
// Module : tick_serial_tx
// Purpose: Tick-paced serial transmitter. Accepts one word per valid/ready
//          handshake and shifts out start bit, DATA_W data bits (LSB first),
//          optional even parity and STOP_BITS stop bits. Bit boundaries fall
//          only on cycles where tick is high; tx is driven from a flop.
// Ports  : clk       in   system clock
//          reset     in   asynchronous active-high reset
//          tick      in   one-cycle bit-period strobe from the divider
//          in_valid  in   upstream word valid
//          in_data   in   word to send (sampled at acceptance only)
//          in_ready  out  high only in IDLE
//          tx        out  serial line, idle high
//          busy      out  high in every state except IDLE
//          done      out  one-cycle pulse on the first IDLE cycle after stop
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int                  c_BCNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [c_BCNT_W-1:0] c_BIT_LAST  = c_BCNT_W'(DATA_W - 1);
  localparam logic                c_STOP_LAST = (STOP_BITS == 2);
  localparam logic                c_PAR_ON    = (PARITY_EN != 0);

  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic [DATA_W-1:0]     r_shreg;
  logic [DATA_W-1:0]     w_shreg_nxt;
  logic [c_BCNT_W-1:0]   r_bit_cnt;
  logic [c_BCNT_W-1:0]   w_bit_cnt_nxt;
  logic                  r_stop_cnt;
  logic                  w_stop_cnt_nxt;
  logic                  r_par;
  logic                  w_par_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  r_done;
  logic                  w_done_nxt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
      r_tx       <= c_LINE_IDLE;
      r_done     <= 1'b0;
    end else begin
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_par      <= w_par_nxt;
      r_tx       <= w_tx_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_par_nxt      = r_par;
    w_done_nxt     = 1'b0;
    w_tx_nxt       = c_LINE_IDLE;

    case (r_state)
      S_IDLE: begin
        // tick is deliberately not looked at here; SYNC waits for the
        // next full period so the start bit is never truncated.
        if (in_valid) begin
          w_shreg_nxt    = in_data;
          w_par_nxt      = ^in_data;
          w_bit_cnt_nxt  = '0;
          w_stop_cnt_nxt = 1'b0;
          w_state_nxt    = S_SYNC;
        end
      end
      S_SYNC: begin
        if (tick) w_state_nxt = S_START;
      end
      S_START: begin
        if (tick) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          w_shreg_nxt   = r_shreg >> 1;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == c_BIT_LAST) begin
            w_state_nxt = c_PAR_ON ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
          w_stop_cnt_nxt = r_stop_cnt + 1'b1;
          if (r_stop_cnt == c_STOP_LAST) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // tx follows the state being entered so it changes on the same edge.
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shreg_nxt[0];
      S_PARITY: w_tx_nxt = w_par_nxt;
      default:  w_tx_nxt = c_LINE_IDLE;
    endcase
  end

  assign tx       = r_tx;
  assign done     = r_done;
  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tick_serial_tx.sv
// ============================================================================
// Module : tb_tick_serial_tx
// Purpose: Self-checking bench for tick_serial_tx. Three instances cover
//          8N1, 8E1 and 8N2 framing; tick arrives every 3 clocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tick_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  int         tcnt = 0;
  wire        tick = (tcnt == 2);
  logic [2:0] vld;
  logic [7:0] dat0, dat1, dat2;
  logic [2:0] rdy, txv, bsy, dn;
  int         chk = 0;
  int         errs = 0;

  always #5 clk = ~clk;

  always @(posedge clk) tcnt <= (tcnt == 2) ? 0 : tcnt + 1;

  tick_serial_tx #(.DATA_W(8), .STOP_BITS(1), .PARITY_EN(0)) u_a (
    .clk(clk), .reset(reset), .tick(tick), .in_valid(vld[0]), .in_data(dat0),
    .in_ready(rdy[0]), .tx(txv[0]), .busy(bsy[0]), .done(dn[0]));

  tick_serial_tx #(.DATA_W(8), .STOP_BITS(1), .PARITY_EN(1)) u_b (
    .clk(clk), .reset(reset), .tick(tick), .in_valid(vld[1]), .in_data(dat1),
    .in_ready(rdy[1]), .tx(txv[1]), .busy(bsy[1]), .done(dn[1]));

  tick_serial_tx #(.DATA_W(8), .STOP_BITS(2), .PARITY_EN(0)) u_c (
    .clk(clk), .reset(reset), .tick(tick), .in_valid(vld[2]), .in_data(dat2),
    .in_ready(rdy[2]), .tx(txv[2]), .busy(bsy[2]), .done(dn[2]));

  task automatic set_in(input int idx, input logic v, input logic [7:0] d);
    vld[idx] = v;
    case (idx)
      0:       dat0 = d;
      1:       dat1 = d;
      default: dat2 = d;
    endcase
  endtask

  // Called on the first falling edge after acceptance. Builds the frame from
  // its definition and follows the line until the done cycle.
  task automatic expect_frame(input int idx, input logic [7:0] d, input int par_en,
                              input int stops, input string tag, output int lat);
    logic [15:0] eb;
    int          nb;
    logic        tk;
    eb = '0;
    nb = 0;
    eb[nb] = 1'b0; nb++;
    for (int i = 0; i < 8; i++) begin eb[nb] = d[i]; nb++; end
    if (par_en != 0) begin eb[nb] = ($countones(d) % 2) == 1; nb++; end
    for (int s = 0; s < stops; s++) begin eb[nb] = 1'b1; nb++; end

    chk++;
    if (rdy[idx] !== 1'b0 || bsy[idx] !== 1'b1 || txv[idx] !== 1'b1) begin
      errs++;
      $display("FAIL %s sync: ready=%b busy=%b tx=%b expected 0 1 1", tag, rdy[idx], bsy[idx], txv[idx]);
    end

    lat = 0;
    for (int i = 0; i < 4; i++) begin
      tk = tick;
      @(negedge clk);
      lat++;
      if (tk) break;
      chk++;
      if (txv[idx] !== 1'b1) begin
        errs++;
        $display("FAIL %s sync_hold: tx=%b expected 1 at cycle %0d", tag, txv[idx], lat);
      end
    end
    chk++;
    if (lat < 1 || lat > 3) begin
      errs++;
      $display("FAIL %s start_latency: got %0d expected 1..3", tag, lat);
    end

    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 3; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        chk++;
        if (txv[idx] !== eb[b] || bsy[idx] !== 1'b1 || dn[idx] !== 1'b0) begin
          errs++;
          $display("FAIL %s bit%0d_cyc%0d: tx=%b busy=%b done=%b expected tx=%b busy=1 done=0",
                   tag, b, c, txv[idx], bsy[idx], dn[idx], eb[b]);
        end
      end
    end

    @(negedge clk);
    chk++;
    if (dn[idx] !== 1'b1 || rdy[idx] !== 1'b1 || txv[idx] !== 1'b1 || bsy[idx] !== 1'b0) begin
      errs++;
      $display("FAIL %s done_cycle: done=%b ready=%b tx=%b busy=%b expected 1 1 1 0",
               tag, dn[idx], rdy[idx], txv[idx], bsy[idx]);
    end
  endtask

  task automatic test_reset();
    chk++;
    if (txv !== 3'b111 || rdy !== 3'b111 || bsy !== 3'b000 || dn !== 3'b000) begin
      errs++;
      $display("FAIL reset_values: tx=%b ready=%b busy=%b done=%b expected 111 111 000 000",
               txv, rdy, bsy, dn);
    end
  endtask

  task automatic test_basic_a5();
    int lat;
    set_in(0, 1'b1, 8'hA5);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    expect_frame(0, 8'hA5, 0, 1, "a5", lat);
    @(negedge clk);
    chk++;
    if (dn[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errs++;
      $display("FAIL a5_done_once: done=%b ready=%b expected 0 1", dn[0], rdy[0]);
    end
  endtask

  task automatic test_parity();
    int lat;
    logic [7:0] vals [2];
    vals[0] = 8'h07;
    vals[1] = 8'h03;
    for (int k = 0; k < 2; k++) begin
      set_in(1, 1'b1, vals[k]);
      @(negedge clk);
      set_in(1, 1'b0, 8'h00);
      expect_frame(1, vals[k], 1, 1, "parity", lat);
      @(negedge clk);
    end
  endtask

  task automatic test_stop2();
    int lat;
    set_in(2, 1'b1, 8'h00);
    @(negedge clk);
    set_in(2, 1'b0, 8'h00);
    expect_frame(2, 8'h00, 0, 2, "stop2", lat);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    set_in(0, 1'b1, 8'h55);
    @(negedge clk);
    set_in(0, 1'b1, 8'hAA);
    expect_frame(0, 8'h55, 0, 1, "b2b_first", lat);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    expect_frame(0, 8'hAA, 0, 1, "b2b_second", lat);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk++;
      if (txv[0] !== 1'b1 || bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
        errs++;
        $display("FAIL b2b_no_dup: tx=%b busy=%b done=%b expected 1 0 0", txv[0], bsy[0], dn[0]);
      end
    end
  endtask

  task automatic test_tick_same_cycle();
    int lat;
    logic [7:0] d;
    d = 8'($urandom);
    for (int i = 0; i < 3 && !tick; i++) @(negedge clk);
    set_in(0, 1'b1, d);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    expect_frame(0, d, 0, 1, "tick_same", lat);
    chk++;
    if (lat != 3) begin
      errs++;
      $display("FAIL tick_same_latency: got %0d expected 3", lat);
    end
    @(negedge clk);
  endtask

  task automatic test_midframe_ignore();
    int lat;
    logic [7:0] d;
    d = 8'($urandom);
    set_in(1, 1'b1, d);
    @(negedge clk);
    set_in(1, 1'b0, 8'h00);
    fork
      expect_frame(1, d, 1, 1, "midframe", lat);
      begin
        repeat (10) @(negedge clk);
        set_in(1, 1'b1, ~d);
        repeat (2) @(negedge clk);
        set_in(1, 1'b0, 8'h00);
      end
    join
    @(negedge clk);
    chk++;
    if (bsy[1] !== 1'b0 || txv[1] !== 1'b1) begin
      errs++;
      $display("FAIL midframe_not_latched: busy=%b tx=%b expected 0 1", bsy[1], txv[1]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int waited;
    logic [7:0] d;
    d = 8'($urandom) & 8'hEF;
    set_in(0, 1'b1, d);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    waited = 0;
    while (txv[0] !== 1'b0 && waited < 5) begin
      @(negedge clk);
      waited++;
    end
    chk++;
    if (txv[0] !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_start: tx=%b expected 0 within 4 cycles", txv[0]);
    end
    repeat (16) @(negedge clk);
    chk++;
    if (txv[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_bit4: tx=%b busy=%b expected 0 1", txv[0], bsy[0]);
    end
    #2 reset = 1'b1;
    #1;
    chk++;
    if (txv[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1 || dn[0] !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_async: tx=%b busy=%b ready=%b done=%b expected 1 0 1 0",
               txv[0], bsy[0], rdy[0], dn[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    set_in(0, 1'b1, 8'h3C);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    expect_frame(0, 8'h3C, 0, 1, "after_reset", lat);
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat;
    int idx;
    logic [7:0] d;
    for (int n = 0; n < 6; n++) begin
      idx = int'($urandom_range(0, 2));
      d   = 8'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      set_in(idx, 1'b1, d);
      @(negedge clk);
      set_in(idx, 1'b0, 8'h00);
      expect_frame(idx, d, (idx == 1) ? 1 : 0, (idx == 2) ? 2 : 1, "random", lat);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    vld   = 3'b000;
    dat0  = 8'h00;
    dat1  = 8'h00;
    dat2  = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_basic_a5();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_tick_same_cycle();
    test_midframe_ignore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errs);
    $fatal(1);
  end

endmodule

`default_nettype wire
